// File: rtl/grey_to_rgb.sv
`default_nettype none
// ============================================================================
// grey_to_rgb : expands grey pixels to RGB by channel replication or through
//               a 16-entry programmable false-colour palette.
// Revision    : 1.0
// ============================================================================
module grey_to_rgb #(
    parameter int GREY_W = 4,
    parameter int CH_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [GREY_W-1:0]    pixel_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [3*CH_W-1:0]    pixel_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 pal_mode,
    input  logic                 pal_we,
    input  logic [GREY_W-1:0]    pal_addr,
    input  logic [3*CH_W-1:0]    pal_data
);

    localparam int c_pal_depth = 2**GREY_W;
    localparam int c_pix_w     = 3*CH_W;

    // Channel bit j (from the MSB) takes grey bit (j mod GREY_W) from the MSB:
    // copies on equal widths, replicates MSBs when widening, truncates LSBs
    // when narrowing.
    function automatic logic [CH_W-1:0] scale_grey(input logic [GREY_W-1:0] g);
        logic [CH_W-1:0] s;
        s = '0;
        for (int j = 0; j < CH_W; j++) begin
            s[CH_W-1-j] = g[GREY_W-1-(j % GREY_W)];
        end
        return s;
    endfunction

    logic [c_pix_w-1:0] pal_q [c_pal_depth];
    logic [c_pix_w-1:0] pal_d [c_pal_depth];

    logic               out_valid_q;
    logic               out_valid_d;
    logic [c_pix_w-1:0] pixel_out_q;
    logic [c_pix_w-1:0] pixel_out_d;

    logic               w_accept;
    logic [CH_W-1:0]    w_chan;
    logic [c_pix_w-1:0] w_conv;

    assign in_ready  = !out_valid_q || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign pixel_out = pixel_out_q;

    always_comb begin
        for (int i = 0; i < c_pal_depth; i++) begin
            pal_d[i] = pal_q[i];
            if (pal_we && (pal_addr == GREY_W'(i))) begin
                pal_d[i] = pal_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_pal_depth; i++) begin
                pal_q[i] <= {3{CH_W'(i)}};
            end
        end else begin
            for (int i = 0; i < c_pal_depth; i++) begin
                pal_q[i] <= pal_d[i];
            end
        end
    end

    // Lookup reads the registered palette, so a same-cycle write is not seen.
    always_comb begin
        w_chan      = scale_grey(pixel_in);
        w_conv      = pal_mode ? pal_q[pixel_in] : {3{w_chan}};
        out_valid_d = out_valid_q;
        pixel_out_d = pixel_out_q;
        if (w_accept) begin
            out_valid_d = 1'b1;
            pixel_out_d = w_conv;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            pixel_out_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            pixel_out_q <= pixel_out_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_grey_to_rgb.sv
`default_nettype none
// ============================================================================
// tb_grey_to_rgb : directed and random stream test for grey_to_rgb.
// Revision       : 1.0
// ============================================================================
module tb_grey_to_rgb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  pixel_in;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] pixel_out;
    logic        out_valid;
    logic        out_ready;
    logic        pal_mode;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [11:0] pal_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    grey_to_rgb #(.GREY_W(4), .CH_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pixel_in  (pixel_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pixel_out (pixel_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pal_mode  (pal_mode),
        .pal_we    (pal_we),
        .pal_addr  (pal_addr),
        .pal_data  (pal_data)
    );

    // Reference: one output slot plus a palette array.
    logic [11:0] m_pal [16];
    logic        m_valid;
    logic [11:0] m_pix;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_pal[i] = {3{i[3:0]}};
            m_valid = 1'b0;
            m_pix   = 12'h000;
        end else begin
            if (in_valid && (!m_valid || out_ready)) begin
                m_pix   = pal_mode ? m_pal[pixel_in] : {3{pixel_in}};
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (pal_we) m_pal[pal_addr] = pal_data;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            n_vec++;
            if (in_ready !== (!m_valid || out_ready) || out_valid !== m_valid ||
                pixel_out !== m_pix) begin
                n_err++;
                $display("FAIL model t=%0t: in_ready=%b want %b out_valid=%b want %b pixel_out=%h want %h",
                         $time, in_ready, (!m_valid || out_ready), out_valid, m_valid, pixel_out, m_pix);
            end
        end
    end

    task automatic check12(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel until the model says it was taken (bounded).
    task automatic send(input logic [3:0] g, input logic mode);
        bit acc;
        acc      = 1'b0;
        pixel_in = g;
        pal_mode = mode;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = !m_valid || out_ready;
            step();
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got no accept expected accept of %h", g);
        end
    endtask

    initial begin
        logic [31:0] r;
        int          acc_cnt;

        rst_n     = 1'b0;
        pixel_in  = 4'h0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pal_mode  = 1'b0;
        pal_we    = 1'b0;
        pal_addr  = 4'h0;
        pal_data  = 12'h000;
        step();
        step();
        check1 ("rst_out_valid", out_valid, 1'b0);
        check1 ("rst_in_ready",  in_ready,  1'b1);
        check12("rst_pixel_out", pixel_out, 12'h000);
        rst_n = 1'b1;
        step();

        // Replicate mode, full-rate stream of 0..15.
        in_valid = 1'b1;
        for (int g = 0; g < 16; g++) begin
            pixel_in = 4'(g);
            step();
            check1 ("t1_valid", out_valid, 1'b1);
            check12("t1_pix",   pixel_out, 12'(12'h111 * g));
        end
        in_valid = 1'b0;
        step();

        // Backpressure hold.
        out_ready = 1'b0;
        send(4'h7, 1'b0);
        in_valid = 1'b1;
        pixel_in = 4'h9;
        for (int k = 0; k < 5; k++) begin
            check12("t2_hold_pix",   pixel_out, 12'h777);
            check1 ("t2_hold_valid", out_valid, 1'b1);
            check1 ("t2_in_ready",   in_ready,  1'b0);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check12("t2_next_pix", pixel_out, 12'h999);
        step();

        // Palette write then lookup.
        pal_we   = 1'b1;
        pal_addr = 4'h3;
        pal_data = 12'hF00;
        step();
        pal_we = 1'b0;
        send(4'h3, 1'b1);
        check12("t3_pal3", pixel_out, 12'hF00);
        send(4'h4, 1'b1);
        check12("t3_pal4", pixel_out, 12'h444);

        // Same-cycle write and lookup sees the old entry.
        pal_we   = 1'b1;
        pal_addr = 4'h5;
        pal_data = 12'h0A0;
        send(4'h5, 1'b1);
        pal_we = 1'b0;
        check12("t4_old", pixel_out, 12'h555);
        send(4'h5, 1'b1);
        check12("t4_new", pixel_out, 12'h0A0);
        send(4'h5, 1'b0);
        check12("t4_mode0", pixel_out, 12'h555);

        // Random traffic against the model.
        acc_cnt = 0;
        for (int c = 0; c < 20000 && acc_cnt < 2000; c++) begin
            r         = $urandom;
            in_valid  = (r[1:0] != 2'b00);
            out_ready = (r[3:2] != 2'b00);
            pal_mode  = r[4];
            pal_we    = (r[7:5] == 3'b000);
            pixel_in  = r[11:8];
            pal_addr  = r[15:12];
            pal_data  = r[27:16];
            if (in_valid && (!m_valid || out_ready)) acc_cnt++;
            step();
        end
        pal_we    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        n_vec++;
        if (acc_cnt < 2000) begin
            n_err++;
            $display("FAIL t5_count: got %0d accepts expected 2000", acc_cnt);
        end

        // Reset while holding a palette-mapped pixel.
        pal_we   = 1'b1;
        pal_addr = 4'h3;
        pal_data = 12'h0F0;
        step();
        pal_we    = 1'b0;
        out_ready = 1'b0;
        send(4'h3, 1'b1);
        check12("t6_before", pixel_out, 12'h0F0);
        #3;
        rst_n = 1'b0;
        #1;
        check1 ("t6_rst_valid", out_valid, 1'b0);
        check1 ("t6_rst_ready", in_ready,  1'b1);
        check12("t6_rst_pix",   pixel_out, 12'h000);
        step();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        send(4'h3, 1'b1);
        check12("t6_ramp", pixel_out, 12'h333);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
